fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch/issue sequencer: a program is loaded into a small memory while idle and
// then issued one word at a time over a valid/ready handshake, counting zero-flag results.
module fetch_unit #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  output logic [31:0]   instruccion_r,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          tr_zf,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   zf_count,
  output logic [AW-1:0] pc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PC_ONE  = AW'(1);

  state_t        state_q;
  logic [31:0]   mem_q [DEPTH];
  logic [AW:0]   len_q;
  logic [AW-1:0] pc_q;
  logic [31:0]   instr_q;
  logic          valid_q;
  logic          busy_q;
  logic          done_q;
  logic [AW:0]   zf_q;
  logic          last_d;

  // Program memory is deliberately outside the reset domain so contents survive a reset.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == S_IDLE)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // len_q is never zero while a run is in progress, so the subtraction cannot underflow.
  assign last_d = ({1'b0, pc_q} == (len_q - CNT_ONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zf_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            zf_q   <= '0;
            busy_q <= 1'b1;
            if (prog_len != '0) begin
              len_q   <= prog_len;
              pc_q    <= '0;
              state_q <= S_FETCH;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_FETCH: begin
          instr_q <= mem_q[pc_q];
          valid_q <= 1'b1;
          state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          if (instr_ready) begin
            valid_q <= 1'b0;
            state_q <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          if (tr_zf) begin
            zf_q <= zf_q + CNT_ONE;
          end
          if (last_d) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            pc_q    <= pc_q + PC_ONE;
            state_q <= S_FETCH;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign instruccion_r = instr_q;
  assign instr_valid   = valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign zf_count      = zf_q;
  assign pc            = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: load, issue with and without back-pressure, zero-flag
// counting, empty program, asynchronous reset mid-run and a full-depth program.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [5:0]  prog_len;
  logic        start;
  logic [31:0] instruccion_r;
  logic        instr_valid;
  logic        instr_ready;
  logic        tr_zf;
  logic        busy;
  logic        done;
  logic [5:0]  zf_count;
  logic [4:0]  pc;

  int checks = 0;
  int errors = 0;
  logic [31:0] prog [32];

  fetch_unit #(.DEPTH(32), .AW(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .prog_len     (prog_len),
    .start        (start),
    .instruccion_r(instruccion_r),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .tr_zf        (tr_zf),
    .busy         (busy),
    .done         (done),
    .zf_count     (zf_count),
    .pc           (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h required %h", tag, obs, exp);
    end
  endtask

  // One complete run: start edge, then FETCH/ISSUE/SAMPLE per word, then DONE and back to IDLE.
  task automatic run_prog(input int len, input logic [31:0] zmask, input int stall,
                          input bit poke, input int exp_zf);
    int cyc;
    cyc = 0;
    prog_len = 6'(len);
    start = 1'b1;
    tick(); cyc++;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("valid_in_fetch", 32'(instr_valid), 32'd0);
    for (int i = 0; i < len; i++) begin
      tick(); cyc++;
      chk("valid_issue", 32'(instr_valid), 32'd1);
      chk("instr", instruccion_r, prog[i]);
      chk("pc", 32'(pc), 32'(i));
      if (i == 0) chk("valid_latency", 32'(cyc), 32'd2);
      tr_zf = ~zmask[i];
      instr_ready = 1'b0;
      if (i == 0) begin
        for (int s = 0; s < stall; s++) begin
          tick(); cyc++;
          chk("stall_valid", 32'(instr_valid), 32'd1);
          chk("stall_instr", instruccion_r, prog[i]);
        end
      end
      if (poke && i == 5) begin
        start = 1'b1;
        prog_len = 6'd0;
        wr_en = 1'b1;
        wr_addr = 5'd31;
        wr_data = 32'hDEADBEEF;
      end
      instr_ready = 1'b1;
      tick(); cyc++;
      instr_ready = 1'b0;
      start = 1'b0;
      wr_en = 1'b0;
      chk("valid_drop", 32'(instr_valid), 32'd0);
      tr_zf = zmask[i];
      tick(); cyc++;
      tr_zf = 1'b0;
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_cycle", 32'(cyc), 32'(3 * len + 1 + stall));
    chk("busy_in_done", 32'(busy), 32'd1);
    tick();
    chk("done_clear", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("zf_count", 32'(zf_count), 32'(exp_zf));
    $display("run len=%0d stall=%0d zf_count=%0d expected=%0d", len, stall, zf_count, exp_zf);
  endtask

  initial begin
    prog[0] = 32'h00A10000;
    prog[1] = 32'h00C45000;
    for (int i = 2; i < 32; i++) prog[i] = 32'h00000820 ^ (32'(i) << 16) ^ 32'(i);

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; prog_len = '0;
    start = 1'b0; instr_ready = 1'b0; tr_zf = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_zf", 32'(zf_count), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_instr", instruccion_r, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = prog[i];
      tick();
    end
    wr_en = 1'b0;

    run_prog(2, 32'h0, 0, 1'b0, 0);
    run_prog(2, 32'h0, 5, 1'b0, 0);
    run_prog(10, 32'h0000_0112, 0, 1'b0, 3);
    tick(); tick(); tick();
    chk("zf_hold_idle", 32'(zf_count), 32'd3);

    // Empty program: straight to DONE, nothing issued, count cleared.
    prog_len = 6'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_busy", 32'(busy), 32'd1);
    chk("len0_valid", 32'(instr_valid), 32'd0);
    chk("len0_zf", 32'(zf_count), 32'd0);
    tick();
    chk("len0_done_clear", 32'(done), 32'd0);
    chk("len0_busy_clear", 32'(busy), 32'd0);
    chk("len0_valid_after", 32'(instr_valid), 32'd0);

    // Asynchronous reset while an instruction is being offered.
    prog_len = 6'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pre_rst_valid", 32'(instr_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(instr_valid), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_instr", instruccion_r, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("no_done_after_rst", 32'(done), 32'd0);
      chk("idle_after_rst", 32'(busy), 32'd0);
    end
    run_prog(2, 32'h0, 0, 1'b0, 0);

    // Full depth, zero flag on every word, start and a write attempted mid-run.
    run_prog(32, 32'hFFFF_FFFF, 0, 1'b1, 32);
    chk("final_pc", 32'(pc), 32'd31);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
